// File: rtl/packet_serializer.sv
// Data-island packet serializer: shifts out a 24-bit header and four 56-bit
// subpackets over 32 pixel clocks, appending BCH parity on every lane.
module packet_serializer (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             data_island_period,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [8:0]       packet_data,
  output logic [4:0]       counter,
  output logic             packet_end
);

  logic [4:0]       cnt_q, cnt_d;
  logic [23:0]      hdr_sh_q, hdr_sh_d;
  logic [3:0][55:0] sub_sh_q, sub_sh_d;
  logic [7:0]       ecc_h_q, ecc_h_d;
  logic [3:0][7:0]  ecc_s_q, ecc_s_d;

  logic             first_clk;
  logic [31:0]      hdr_ext;
  logic [3:0][63:0] sub_ext;
  logic             hdr_bit;
  logic [3:0]       even_bit;
  logic [3:0]       odd_bit;

  // One LSB-first step of the x^8+x^7+x^6+1 BCH parity generator.
  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    logic fb;
    fb = e[0] ^ b;
    return {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
  endfunction

  // State register
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      hdr_sh_q <= '0;
      sub_sh_q <= '0;
      ecc_h_q  <= '0;
      ecc_s_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hdr_sh_q <= hdr_sh_d;
      sub_sh_q <= sub_sh_d;
      ecc_h_q  <= ecc_h_d;
      ecc_s_q  <= ecc_s_d;
    end
  end

  // Bit selection: clock 0 reads the live inputs, later clocks the shadow copy.
  always_comb begin
    first_clk = (cnt_q == 5'd0);
    hdr_ext   = {8'h00, (first_clk ? header : hdr_sh_q)};
    hdr_bit   = hdr_ext[cnt_q];
    sub_ext   = '0;
    even_bit  = '0;
    odd_bit   = '0;
    for (int k = 0; k < 4; k++) begin
      sub_ext[k]  = {8'h00, (first_clk ? sub[k] : sub_sh_q[k])};
      even_bit[k] = sub_ext[k][{cnt_q, 1'b0}];
      odd_bit[k]  = sub_ext[k][{cnt_q, 1'b1}];
    end
  end

  // Next-state logic
  always_comb begin
    cnt_d    = data_island_period ? cnt_q + 5'd1 : 5'd0;
    hdr_sh_d = hdr_sh_q;
    sub_sh_d = sub_sh_q;
    ecc_h_d  = ecc_h_q;
    ecc_s_d  = ecc_s_q;

    if (data_island_period && first_clk) begin
      hdr_sh_d = header;
      sub_sh_d = sub;
    end

    // Parity restarts from a zero seed on clock 0, so an aborted packet
    // never leaks into the next one.
    if (data_island_period && (cnt_q < 5'd24)) begin
      ecc_h_d = bch_step(first_clk ? 8'h00 : ecc_h_q, hdr_bit);
    end
    if (data_island_period && (cnt_q < 5'd28)) begin
      for (int k = 0; k < 4; k++) begin
        ecc_s_d[k] = bch_step(bch_step(first_clk ? 8'h00 : ecc_s_q[k],
                                       even_bit[k]), odd_bit[k]);
      end
    end
  end

  // Output logic
  always_comb begin
    packet_data = '0;
    counter     = cnt_q;
    packet_end  = data_island_period && (cnt_q == 5'd31);
    if (data_island_period && reset) begin
      // Parity index is counter-24 (header) or counter-28 (subpackets),
      // which reduces to the low counter bits in those windows.
      packet_data[0] = (cnt_q < 5'd24) ? hdr_bit : ecc_h_q[cnt_q[2:0]];
      for (int k = 0; k < 4; k++) begin
        if (cnt_q < 5'd28) begin
          packet_data[1+k] = even_bit[k];
          packet_data[5+k] = odd_bit[k];
        end else begin
          packet_data[1+k] = ecc_s_q[k][{cnt_q[1:0], 1'b0}];
          packet_data[5+k] = ecc_s_q[k][{cnt_q[1:0], 1'b1}];
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: table of packets streamed back-to-back through
// a scoreboard, plus hand-written idle, capture, abort and async-reset sequences.
module tb_packet_serializer;

  logic             clk_pixel;
  logic             reset;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [8:0]       packet_data;
  logic [4:0]       counter;
  logic             packet_end;

  packet_serializer dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_data        (packet_data),
    .counter            (counter),
    .packet_end         (packet_end)
  );

  // ---------------- clock ----------------
  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Word layout: {packet_end, counter[4:0], packet_data[8:0]}
  logic [14:0] exp_q[$];
  logic [14:0] model_w [32];
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [14:0] MASK_ALL   = 15'h7FFF;
  localparam logic [14:0] MASK_NOCNT = 15'h41FF;

  task automatic check(input string nm, input logic [14:0] act,
                       input logic [14:0] exp, input logic [14:0] mask);
    n_cmp++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s @%0t: got end=%0b cnt=%0d data=%03h, expected end=%0b cnt=%0d data=%03h",
               nm, $time, act[14], act[13:9], act[8:0], exp[14], exp[13:9], exp[8:0]);
    end
  endtask

  always @(negedge clk_pixel) begin
    if (reset && data_island_period) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow @%0t: output seen with no expected word", $time);
      end else begin
        check("stream", {packet_end, counter, packet_data}, exp_q.pop_front(), MASK_ALL);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_bch(input logic [7:0] e, input logic b);
    logic [7:0] r;
    r = e >> 1;
    if (e[0] ^ b) r = r ^ 8'b1000_0011;
    return r;
  endfunction

  task automatic build_model(input logic [23:0] hdr, input logic [3:0][55:0] sb,
                             input logic use_c, input logic [7:0] ecc_c);
    logic [7:0]  eh;
    logic [7:0]  es;
    logic [31:0] hs;
    logic [63:0] ss [4];
    logic [8:0]  pd;
    logic [4:0]  c5;
    eh = 8'h00;
    for (int i = 0; i < 24; i++) eh = ref_bch(eh, hdr[i]);
    if (use_c) eh = ecc_c;
    hs = {eh, hdr};
    for (int k = 0; k < 4; k++) begin
      es = 8'h00;
      for (int i = 0; i < 28; i++) es = ref_bch(ref_bch(es, sb[k][2*i]), sb[k][2*i+1]);
      ss[k] = {es, sb[k]};
    end
    for (int c = 0; c < 32; c++) begin
      pd[0] = hs[c];
      for (int k = 0; k < 4; k++) begin
        pd[1+k] = ss[k][2*c];
        pd[5+k] = ss[k][2*c+1];
      end
      c5 = c[4:0];
      model_w[c] = {(c == 31), c5, pd};
    end
  endtask

  // ---------------- drivers ----------------
  // Called just after a rising edge; leaves the bench just after a rising edge.
  task automatic drive_packet(input logic [23:0] hdr, input logic [3:0][55:0] sb,
                              input int n_cyc, input int chg_at, input logic [23:0] chg_hdr,
                              input logic use_c, input logic [7:0] ecc_c);
    build_model(hdr, sb, use_c, ecc_c);
    for (int i = 0; i < n_cyc; i++) exp_q.push_back(model_w[i]);
    header = hdr;
    sub = sb;
    data_island_period = 1'b1;
    for (int c = 0; c < n_cyc; c++) begin
      if (c == chg_at) header = chg_hdr;
      @(posedge clk_pixel); #1;
    end
  endtask

  task automatic idle_cycles(input int n, input logic chk_cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_pixel);
      check("idle", {packet_end, counter, packet_data}, 15'h0000,
            chk_cnt ? MASK_ALL : MASK_NOCNT);
      @(posedge clk_pixel); #1;
    end
  endtask

  function automatic logic [55:0] rand56();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[55:0];
  endfunction

  typedef struct {
    logic [23:0]      hdr;
    logic [3:0][55:0] sb;
    logic             ecc_valid;
    logic [7:0]       ecc_h;
  } vec_t;

  vec_t vecs [6];
  logic [3:0][55:0] sb_a;
  logic [3:0][55:0] sb_b;

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{hdr: 24'h000000, sb: '0, ecc_valid: 1'b1, ecc_h: 8'h00};
    vecs[1] = '{hdr: 24'h000001, sb: '0, ecc_valid: 1'b1, ecc_h: 8'h4A};
    vecs[2] = '{hdr: 24'h000000, sb: '0, ecc_valid: 1'b0, ecc_h: 8'h00};
    vecs[2].sb[2] = 56'h1;
    vecs[3] = '{hdr: 24'hABCDEF, sb: '0, ecc_valid: 1'b0, ecc_h: 8'h00};
    vecs[3].sb[0] = 56'hFF_FFFF_FFFF_FFFF;
    vecs[3].sb[1] = 56'hAA_AAAA_AAAA_AAAA;
    vecs[3].sb[2] = 56'h55_5555_5555_5555;
    vecs[3].sb[3] = 56'h80_0000_0000_0001;
    for (int i = 4; i < 6; i++) begin
      vecs[i].hdr = 24'($urandom);
      for (int k = 0; k < 4; k++) vecs[i].sb[k] = rand56();
      vecs[i].ecc_valid = 1'b0;
      vecs[i].ecc_h = 8'h00;
    end

    data_island_period = 1'b0;
    header = '0;
    sub = '0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held, then idle after release.
    @(posedge clk_pixel); #1;
    idle_cycles(3, 1'b1);
    reset = 1'b1;
    idle_cycles(4, 1'b1);

    // Table packets streamed back-to-back.
    for (int i = 0; i < 6; i++) begin
      drive_packet(vecs[i].hdr, vecs[i].sb, 32, -1, 24'h0,
                   vecs[i].ecc_valid, vecs[i].ecc_h);
    end
    data_island_period = 1'b0;
    idle_cycles(2, 1'b1);

    // Header changes after capture; next packet picks up the new value.
    for (int k = 0; k < 4; k++) sb_a[k] = rand56();
    drive_packet(24'h5A5A5A, sb_a, 32, 5, 24'hFFFFFF, 1'b0, 8'h00);
    drive_packet(24'hFFFFFF, sb_a, 32, -1, 24'h0, 1'b0, 8'h00);
    data_island_period = 1'b0;
    idle_cycles(1, 1'b1);

    // Abort at counter 10, three idle clocks, then a clean packet.
    for (int k = 0; k < 4; k++) sb_b[k] = rand56();
    drive_packet(24'h123456, sb_a, 10, -1, 24'h0, 1'b0, 8'h00);
    data_island_period = 1'b0;
    idle_cycles(1, 1'b0);
    idle_cycles(2, 1'b1);
    drive_packet(24'h654321, sb_b, 32, -1, 24'h0, 1'b0, 8'h00);

    // Asynchronous reset at counter 17.
    drive_packet(24'hC0FFEE, sb_b, 17, -1, 24'h0, 1'b0, 8'h00);
    #1 reset = 1'b0;
    #1 check("async_reset", {packet_end, counter, packet_data}, 15'h0000, MASK_ALL);
    idle_cycles(2, 1'b1);
    data_island_period = 1'b0;
    reset = 1'b1;
    idle_cycles(2, 1'b1);

    // Recovery after reset.
    drive_packet(24'hC0FFEE, sb_b, 32, -1, 24'h0, 1'b0, 8'h00);
    data_island_period = 1'b0;
    idle_cycles(1, 1'b1);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected words never produced, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Consumes one data-island packet (24-bit header plus four 56-bit subpackets) from an info-frame or audio-sample packet generator.
- Serializes it over 32 pixel clocks and appends the BCH parity bytes.
- Feeds the TERC4 channel mapper: 1 header bit and 8 subpacket bits per clock.
- Sits directly downstream of the info-frame generators and upstream of TERC4 encoding.

Parameters:
- None. Packet geometry is fixed at 32 clocks per packet, 24+8 header bits and 56+8 bits per subpacket.

Ports:
- clk_pixel  input  1  pixel clock
- reset  input  1  asynchronous, active-low reset
- data_island_period  input  1  high while packet transmission is allowed; low forces idle
- header  input  24  header bytes HB2..HB0; bit 0 is sent first
- sub  input  4x56  subpackets 0..3; bit 0 of each is sent first
- packet_data  output  9  [0]=header bit; [4:1]=even bit of sub0..3; [8:5]=odd bit of sub0..3
- counter  output  5  clock index within the current packet, 0..31
- packet_end  output  1  high during the final clock (counter==31) of a packet

Behaviour:
- Reset (reset low, asynchronous):
  - counter=0; header ECC, all subpacket ECC registers and the shadow registers clear to 0.
  - packet_data=0, packet_end=0.
- Counter:
  - When data_island_period is high, counter increments every clk_pixel and wraps 31->0. Packets are back-to-back with no gap.
  - When data_island_period is low, counter is held at 0, packet_data=0 and packet_end=0.
- Input capture:
  - On the cycle with counter==0 and data_island_period high, header and sub are copied into shadow registers at the clock edge.
  - Output bit 0 of that cycle comes from the live inputs. Counters 1..31 take data from the shadow copy.
  - Upstream may change header/sub any time after the counter==0 cycle.
- Header lane (packet_data[0]):
  - Counters 0..23: header bit [counter].
  - Counters 24..31: ecc_h[counter-24], LSB first.
- Subpacket lanes, k=0..3:
  - Counters 0..27: packet_data[1+k]=sub[k][2*counter] and packet_data[5+k]=sub[k][2*counter+1].
  - Counters 28..31: the same two lanes carry ecc_k[2*(counter-28)] and ecc_k[2*(counter-28)+1].
- BCH step function, 8-bit state e and input bit b:
  - fb = e[0]^b.
  - e' = {1'b0,e[7:1]} ^ (fb ? 8'h83 : 8'h00).
  - Polynomial is x^8+x^7+x^6+1, LSB-first.
- ECC registers:
  - Header: when counter<24, ecc_h <= step(seed, header bit). Seed is 0 when counter==0, else ecc_h.
  - Subpackets: when counter<28, ecc_k <= step(step(seed, even bit), odd bit), even bit first. Seed is 0 when counter==0, else ecc_k.
  - Otherwise the registers hold.
  - ECC output bits are read combinationally from the held registers.
- packet_end is combinational: data_island_period && counter==31.
- Mid-packet deassertion of data_island_period:
  - The packet is abandoned and counter returns to 0 on the next edge.
  - Re-assertion always starts a fresh packet with a zero ECC seed.
  - No partial packet is ever resumed.
- Latency: 0. Header bit 0 appears on packet_data in the same cycle data_island_period first goes high.
- Reset mid-packet: all state clears immediately; the output is 0 until reset is released and data_island_period is high.

Test Plan:
- Reset then idle: reset low, data_island_period=0 -> counter=0, packet_data=9'h000, packet_end=0 for all cycles.
- All-zero packet: header=0, sub=0, 32 clocks enabled -> packet_data=0 every cycle including the ECC bits; packet_end high only at counter 31.
- Header single bit: header=24'h000001, sub=0 -> lane 0 = 1 at counter 0, then 0 through counter 23. ECC = 8'h4A, so counters 24..31 give lane 0 = 0,1,0,1,0,0,1,0.
- Subpacket mapping: sub[2]=56'h1, others 0 -> counter 0 gives packet_data[3]=1 and packet_data[7]=0. Counters 28..31 on lanes 3/7 carry the ECC of sub[2], which must match the reference model. All other lanes stay 0.
- Input change after capture: header changes to 24'hFFFFFF at counter 5 -> header lane keeps sending the captured value and its ECC for the whole packet. The next packet sends all ones with the matching ECC.
- Abort: drop data_island_period at counter 10, re-assert 3 cycles later -> counter restarts at 0, and the ECC equals that of a clean packet for the new inputs.
- Async reset at counter 17 -> counter=0 and packet_data=0 immediately, without waiting for a clock edge.
